// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the add/subtract command sequencer:
// FSM state encoding, datapath operation codes and latency counter width.
package adder_seq_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        HOLD  = 2'b11
    } seq_state_t;

    // Datapath operation codes driven on MODO
    localparam logic [1:0] MODO_HOLD = 2'b00;
    localparam logic [1:0] MODO_ADD  = 2'b01;
    localparam logic [1:0] MODO_SUB  = 2'b10;
    localparam logic [1:0] MODO_CLR  = 2'b11;

    // Latency counter width; covers LAT values 1..15
    localparam int CNT_W = 4;

endpackage

// File: rtl/seq_lat_counter.sv
// Loadable down-counter with a zero flag. Times the datapath latency
// between the issue cycle and the result capture edge.
module seq_lat_counter
    import adder_seq_pkg::*;
(
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_reg;

    // Load takes priority; decrement saturates at zero
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/adder_op_sequencer.sv
// Command sequencer for the clocked add/subtract datapath. Accepts one
// operation over a valid/ready handshake, pulses ENB for one issue cycle,
// waits LAT cycles, captures Q/RCO and presents the result downstream.
// Only one operation is in flight at a time.
// Optional feature: define SEQ_ACCUM_EN to add the in_acc input, which takes
// operand A and Cin from the previous result for multi-word chaining.
module adder_op_sequencer
    import adder_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LAT   = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    // command input
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_A,
    input  logic [WIDTH-1:0] in_B,
    input  logic             in_Cin,
    input  logic [1:0]       in_MODO,
`ifdef SEQ_ACCUM_EN
    input  logic             in_acc,
`endif
    // datapath drive
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             Cin,
    output logic             ENB,
    output logic [1:0]       MODO,
    // datapath result
    input  logic [WIDTH-1:0] Q,
    input  logic             RCO,
    // result output
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_Q,
    output logic             res_RCO
);

    if (LAT < 1 || LAT > 15) begin : g_lat_range_check
        $error("adder_op_sequencer: LAT must be in 1..15");
    end

    seq_state_t state_reg;
    logic       cnt_zero;

    // Counter is loaded while issuing and runs down during WAIT
    seq_lat_counter u_lat_counter (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .load     (state_reg == ISSUE),
        .load_val (CNT_W'(LAT - 1)),
        .dec      (state_reg == WAIT),
        .zero     (cnt_zero)
    );

    // Control FSM with registered handshake/datapath outputs; A/B/Cin act as
    // the operand registers and keep their values outside ISSUE
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg <= IDLE;
            in_ready  <= 1'b1;
            res_valid <= 1'b0;
            ENB       <= 1'b0;
            MODO      <= MODO_HOLD;
            A         <= '0;
            B         <= '0;
            Cin       <= 1'b0;
            res_Q     <= '0;
            res_RCO   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready) begin
`ifdef SEQ_ACCUM_EN
                        if (in_acc) begin
                            A   <= res_Q;
                            Cin <= res_RCO;
                        end else begin
                            A   <= in_A;
                            Cin <= in_Cin;
                        end
`else
                        A   <= in_A;
                        Cin <= in_Cin;
`endif
                        B         <= in_B;
                        MODO      <= in_MODO;
                        ENB       <= 1'b1;
                        in_ready  <= 1'b0;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    ENB       <= 1'b0;
                    MODO      <= MODO_HOLD;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (cnt_zero) begin
                        res_Q     <= Q;
                        res_RCO   <= RCO;
                        res_valid <= 1'b1;
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    in_ready  <= 1'b1;
                    res_valid <= 1'b0;
                    ENB       <= 1'b0;
                    MODO      <= MODO_HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_op_sequencer.sv
// Self-checking bench for adder_op_sequencer with a reference datapath model
// (accumulator register followed by a LAT-deep delay line). Expected results
// are queued at issue time and compared when res_valid appears.
module tb_adder_op_sequencer;
    import adder_seq_pkg::*;

    localparam int WIDTH = 8;
    localparam int LAT   = 2;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_A = '0;
    logic [WIDTH-1:0] in_B = '0;
    logic             in_Cin = 1'b0;
    logic [1:0]       in_MODO = 2'b00;
`ifdef SEQ_ACCUM_EN
    logic             in_acc = 1'b0;
`endif
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             ENB;
    logic [1:0]       MODO;
    logic [WIDTH-1:0] Q;
    logic             RCO;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [WIDTH-1:0] res_Q;
    logic             res_RCO;

    int checks = 0;
    int errors = 0;

    logic [WIDTH:0] exp_q[$];          // scoreboard of {RCO,Q}
    logic [WIDTH:0] exp_acc  = '0;     // bench view of the datapath accumulator
    logic [WIDTH:0] last_res = '0;     // bench view of res_RCO/res_Q
    logic [WIDTH-1:0] last_op_a = '0;
    logic [WIDTH-1:0] last_op_b = '0;
    logic             last_op_cin = 1'b0;

    always #5 CLK = ~CLK;

    function automatic logic [WIDTH:0] ref_op(input logic [WIDTH:0] prev,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic cin,
                                              input logic [1:0] m);
        case (m)
            2'b00:   return prev;
            2'b01:   return {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
            2'b10:   return {1'b0, a} - {1'b0, b} - (WIDTH+1)'(cin);
            default: return '0;
        endcase
    endfunction

    // Reference datapath: accumulator updated on ENB, then a delay line
    logic [WIDTH:0] dp_stage [LAT] = '{default: '0};
    always @(posedge CLK) begin
        if (ENB) dp_stage[0] <= ref_op(dp_stage[0], A, B, Cin, MODO);
        for (int i = 1; i < LAT; i++) dp_stage[i] <= dp_stage[i-1];
    end
    assign Q   = dp_stage[LAT-1][WIDTH-1:0];
    assign RCO = dp_stage[LAT-1][WIDTH];

    adder_op_sequencer #(.WIDTH(WIDTH), .LAT(LAT)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_A      (in_A),
        .in_B      (in_B),
        .in_Cin    (in_Cin),
        .in_MODO   (in_MODO),
`ifdef SEQ_ACCUM_EN
        .in_acc    (in_acc),
`endif
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .ENB       (ENB),
        .MODO      (MODO),
        .Q         (Q),
        .RCO       (RCO),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_Q     (res_Q),
        .res_RCO   (res_RCO)
    );

    // Drive one command; returns at the negedge inside the ISSUE cycle
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic cin, input logic [1:0] m, input logic acc);
        int n;
        n = 0;
        @(negedge CLK);
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
            return;
        end
        last_op_a   = acc ? last_res[WIDTH-1:0] : a;
        last_op_cin = acc ? last_res[WIDTH] : cin;
        last_op_b   = b;
        exp_acc     = ref_op(exp_acc, last_op_a, b, last_op_cin, m);
        exp_q.push_back(exp_acc);
        in_valid = 1'b1;
        in_A     = a;
        in_B     = b;
        in_Cin   = cin;
        in_MODO  = m;
`ifdef SEQ_ACCUM_EN
        in_acc   = acc;
`endif
        @(negedge CLK);
        in_valid = 1'b0;
        in_A     = ~a;
        in_B     = ~b;
        in_Cin   = ~cin;
        in_MODO  = ~m;
`ifdef SEQ_ACCUM_EN
        in_acc   = 1'b0;
`endif
        checks++;
        if (ENB !== 1'b1 || MODO !== m || A !== last_op_a || B !== b || Cin !== last_op_cin || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL issue_drive: ENB=%b MODO=%b A=%h B=%h Cin=%b in_ready=%b required 1 %b %h %h %b 0",
                     ENB, MODO, A, B, Cin, in_ready, m, last_op_a, b, last_op_cin);
        end
    endtask

    // Wait for the result, compare against the scoreboard, optionally stall
    task automatic collect(input string name, input int stall);
        int k;
        int enb_cnt;
        logic [WIDTH:0] exp;
        k = 0;
        enb_cnt = 0;
        while (res_valid !== 1'b1 && k < 40) begin
            if (ENB === 1'b1) enb_cnt++;
            @(negedge CLK);
            k++;
        end
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_res_valid: res_valid=%b required 1 within 40 cycles", name, res_valid);
        end
        checks++;
        if (k != LAT + 1) begin
            errors++;
            $display("FAIL %s_latency: %0d cycles required %0d", name, k, LAT + 1);
        end
        checks++;
        if (enb_cnt != 1) begin
            errors++;
            $display("FAIL %s_enb_width: ENB high %0d cycles required 1", name, enb_cnt);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        checks++;
        if ({res_RCO, res_Q} !== exp) begin
            errors++;
            $display("FAIL %s_result: res_RCO=%b res_Q=%h required %b %h", name, res_RCO, res_Q, exp[WIDTH], exp[WIDTH-1:0]);
        end
        checks++;
        if (A !== last_op_a || B !== last_op_b || Cin !== last_op_cin || ENB !== 1'b0 || MODO !== 2'b00) begin
            errors++;
            $display("FAIL %s_idle_drive: A=%h B=%h Cin=%b ENB=%b MODO=%b required %h %h %b 0 00",
                     name, A, B, Cin, ENB, MODO, last_op_a, last_op_b, last_op_cin);
        end
        $display("%s: res_Q=%h res_RCO=%b latency=%0d stall=%0d", name, res_Q, res_RCO, k, stall);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            in_A     = 8'hA5;
            in_MODO  = 2'b01;
            @(negedge CLK);
            checks++;
            if (res_valid !== 1'b1 || {res_RCO, res_Q} !== exp || in_ready !== 1'b0 || ENB !== 1'b0) begin
                errors++;
                $display("FAIL %s_stall%0d: res_valid=%b res=%h in_ready=%b ENB=%b required 1 %h 0 0",
                         name, s, res_valid, {res_RCO, res_Q}, in_ready, ENB, exp);
            end
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(negedge CLK);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_release: res_valid=%b in_ready=%b required 0 1", name, res_valid, in_ready);
        end
        checks++;
        if ({res_RCO, res_Q} !== exp) begin
            errors++;
            $display("FAIL %s_retain: res=%h required %h", name, {res_RCO, res_Q}, exp);
        end
        last_res = exp;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        checks++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0 || ENB !== 1'b0 || MODO !== 2'b00 ||
            A !== '0 || B !== '0 || Cin !== 1'b0 || res_Q !== '0 || res_RCO !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b rv=%b ENB=%b MODO=%b A=%h B=%h Cin=%b resQ=%h resRCO=%b required 1 0 0 00 00 00 0 00 0",
                     in_ready, res_valid, ENB, MODO, A, B, Cin, res_Q, res_RCO);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        checks++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0 || ENB !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b res_valid=%b ENB=%b required 1 0 0", in_ready, res_valid, ENB);
        end
        $display("reset: in_ready=%b res_valid=%b", in_ready, res_valid);
    endtask

    task automatic test_add();
        issue(8'h3A, 8'h47, 1'b0, MODO_ADD, 1'b0);
        collect("add", 0);
        checks++;
        if (res_Q !== 8'h81 || res_RCO !== 1'b0) begin
            errors++;
            $display("FAIL add_const: res_Q=%h res_RCO=%b required 81 0", res_Q, res_RCO);
        end
    endtask

    task automatic test_sub();
        issue(8'h10, 8'h20, 1'b0, MODO_SUB, 1'b0);
        collect("sub", 0);
        checks++;
        if (res_Q !== 8'hF0 || res_RCO !== 1'b1) begin
            errors++;
            $display("FAIL sub_const: res_Q=%h res_RCO=%b required f0 1", res_Q, res_RCO);
        end
    endtask

    task automatic test_stall();
        issue(8'h01, 8'h02, 1'b1, MODO_ADD, 1'b0);
        collect("stall", 5);
    endtask

    task automatic test_reset_wait();
        issue(8'h12, 8'h34, 1'b0, MODO_ADD, 1'b0);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if (ENB !== 1'b0 || res_valid !== 1'b0 || in_ready !== 1'b1 || MODO !== 2'b00 || res_Q !== '0) begin
            errors++;
            $display("FAIL reset_wait_abort: ENB=%b res_valid=%b in_ready=%b MODO=%b res_Q=%h required 0 0 1 00 00",
                     ENB, res_valid, in_ready, MODO, res_Q);
        end
        $display("reset_wait: aborted, in_ready=%b", in_ready);
        exp_q.delete();
        last_res = '0;
        @(negedge CLK);
        RST_N = 1'b1;
        issue(8'h0F, 8'h01, 1'b1, MODO_ADD, 1'b0);
        collect("after_reset", 0);
    endtask

    task automatic test_clear_hold();
        issue(8'hFF, 8'h00, 1'b0, MODO_CLR, 1'b0);
        collect("clear", 0);
        checks++;
        if (res_Q !== 8'h00 || res_RCO !== 1'b0) begin
            errors++;
            $display("FAIL clear_const: res_Q=%h res_RCO=%b required 00 0", res_Q, res_RCO);
        end
        issue(8'h55, 8'h22, 1'b0, MODO_ADD, 1'b0);
        collect("pre_hold", 0);
        issue(8'h11, 8'h22, 1'b1, MODO_HOLD, 1'b0);
        collect("hold", 0);
        checks++;
        if (res_Q !== 8'h77 || res_RCO !== 1'b0) begin
            errors++;
            $display("FAIL hold_const: res_Q=%h res_RCO=%b required 77 0", res_Q, res_RCO);
        end
    endtask

`ifdef SEQ_ACCUM_EN
    task automatic test_accum();
        issue(8'hFF, 8'h01, 1'b0, MODO_ADD, 1'b0);
        collect("accum_lo", 0);
        checks++;
        if (res_Q !== 8'h00 || res_RCO !== 1'b1) begin
            errors++;
            $display("FAIL accum_lo_const: res_Q=%h res_RCO=%b required 00 1", res_Q, res_RCO);
        end
        issue(8'h5A, 8'h00, 1'b0, MODO_ADD, 1'b1);
        collect("accum_hi", 0);
        checks++;
        if (res_Q !== 8'h01 || res_RCO !== 1'b0) begin
            errors++;
            $display("FAIL accum_hi_const: res_Q=%h res_RCO=%b required 01 0", res_Q, res_RCO);
        end
    endtask
`endif

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            logic [WIDTH-1:0] a;
            logic [WIDTH-1:0] b;
            logic             c;
            logic [1:0]       m;
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            c = 1'($urandom);
            m = ($urandom_range(0, 1) == 0) ? MODO_ADD : MODO_SUB;
            issue(a, b, c, m, 1'b0);
            collect($sformatf("b2b%0d", i), 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_stall();
        test_reset_wait();
        test_clear_hold();
`ifdef SEQ_ACCUM_EN
        test_accum();
`endif
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
